bp_be_stride_detector: RTL and testbench

Single-entry striding-load detector and prefetch issuer in the BE checker. It trains on committed loads and drives the loop-inference discovery handshake (`start_discovery`, `confirm_discovery`, `striding_pc`). It then consumes the returned remaining-iteration estimate and emits up to `max_prefetch_p` stride-ahead prefetch addresses over a valid/ready port. It is the initiator and consumer end of the loop-inference interface.

---
 rtl/bp_be_stride_detector.sv | 198 +++++++++++++++++++
 tb/tb_bp_be_stride_detector.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_stride_detector.sv
// Single-entry striding-load detector: trains on committed loads, drives the
// loop-inference discovery handshake, then issues stride-ahead prefetches.
module bp_be_stride_detector #(
    parameter int vaddr_width_p    = 39,
    parameter int output_range_p   = 8,
    parameter int stride_width_p   = 16,
    parameter int conf_threshold_p = 3,
    parameter int max_prefetch_p   = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic                      ld_v_i,
    input  logic [vaddr_width_p-1:0]  ld_pc_i,
    input  logic [vaddr_width_p-1:0]  ld_eaddr_i,

    output logic                      start_discovery_o,
    output logic                      confirm_discovery_o,
    output logic [vaddr_width_p-1:0]  striding_pc_o,

    input  logic [output_range_p-1:0] remaining_iterations_i,
    input  logic                      v_i,
    output logic                      yumi_o,

    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_addr_o,
    input  logic                      pf_ready_i
);

    localparam int conf_width_lp = $clog2(conf_threshold_p + 1);
    localparam int cnt_width_lp  = $clog2(max_prefetch_p + 1);

    typedef enum logic [1:0] {TRAIN, DISCOVER, WAIT_CNT, PREFETCH} state_e;

    state_e                     state_q, state_d;
    logic                       entry_v_q, entry_v_d;
    logic [vaddr_width_p-1:0]   pc_q, pc_d;
    logic [vaddr_width_p-1:0]   last_addr_q, last_addr_d;
    logic [stride_width_p-1:0]  stride_q, stride_d;
    logic [conf_width_lp-1:0]   conf_q, conf_d;
    logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
    logic [vaddr_width_p-1:0]   next_addr_q, next_addr_d;
    logic                       start_q, start_d;
    logic                       confirm_q, confirm_d;

    logic [vaddr_width_p-1:0]   new_stride;
    logic [vaddr_width_p-1:0]   stride_sext;
    logic [vaddr_width_p-stride_width_p:0] stride_hi;
    logic                       stride_fits;
    logic                       stride_match;
    logic                       pc_eq;
    logic [stride_width_p-1:0]  learned_stride;
    logic [conf_width_lp-1:0]   conf_inc;
    logic [cnt_width_lp-1:0]    cnt_capped;

    // The stride fits the narrow register when every bit above its sign bit
    // is a copy of that sign bit.
    assign new_stride     = ld_eaddr_i - last_addr_q;
    assign stride_sext    = {{(vaddr_width_p-stride_width_p){stride_q[stride_width_p-1]}}, stride_q};
    assign stride_hi      = new_stride[vaddr_width_p-1:stride_width_p-1];
    assign stride_fits    = (&stride_hi) | ~(|stride_hi);
    assign stride_match   = stride_fits && (|new_stride) && (new_stride == stride_sext);
    assign pc_eq          = (ld_pc_i == pc_q);
    assign learned_stride = stride_fits ? new_stride[stride_width_p-1:0] : '0;
    assign conf_inc       = conf_q + conf_width_lp'(1);
    assign cnt_capped     = (int'(remaining_iterations_i) > max_prefetch_p)
                          ? cnt_width_lp'(max_prefetch_p)
                          : cnt_width_lp'(remaining_iterations_i);

    // NOTE: every state bit is reset asynchronously and updated with
    // non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= TRAIN;
            entry_v_q   <= 1'b0;
            pc_q        <= '0;
            last_addr_q <= '0;
            stride_q    <= '0;
            conf_q      <= '0;
            cnt_q       <= '0;
            next_addr_q <= '0;
            start_q     <= 1'b0;
            confirm_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_v_q   <= entry_v_d;
            pc_q        <= pc_d;
            last_addr_q <= last_addr_d;
            stride_q    <= stride_d;
            conf_q      <= conf_d;
            cnt_q       <= cnt_d;
            next_addr_q <= next_addr_d;
            start_q     <= start_d;
            confirm_q   <= confirm_d;
        end
    end

    // NOTE: every signal driven here gets a hold/default value first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d     = state_q;
        entry_v_d   = entry_v_q;
        pc_d        = pc_q;
        last_addr_d = last_addr_q;
        stride_d    = stride_q;
        conf_d      = conf_q;
        cnt_d       = cnt_q;
        next_addr_d = next_addr_q;
        start_d     = 1'b0;
        confirm_d   = 1'b0;

        unique case (state_q)
            TRAIN: begin
                if (ld_v_i) begin
                    if (!entry_v_q || (!pc_eq && conf_q == '0)) begin
                        entry_v_d   = 1'b1;
                        pc_d        = ld_pc_i;
                        last_addr_d = ld_eaddr_i;
                        stride_d    = '0;
                        conf_d      = '0;
                    end else if (pc_eq) begin
                        last_addr_d = ld_eaddr_i;
                        if (stride_match) begin
                            conf_d  = conf_width_lp'(1);
                            start_d = 1'b1;
                            state_d = DISCOVER;
                        end else begin
                            stride_d = learned_stride;
                            conf_d   = '0;
                        end
                    end
                end
            end

            DISCOVER: begin
                if (ld_v_i && pc_eq) begin
                    last_addr_d = ld_eaddr_i;
                    if (stride_match) begin
                        conf_d = conf_inc;
                        if (conf_inc == conf_width_lp'(conf_threshold_p)) begin
                            confirm_d = 1'b1;
                            state_d   = WAIT_CNT;
                        end
                    end else begin
                        stride_d = learned_stride;
                        conf_d   = '0;
                        state_d  = TRAIN;
                    end
                end
            end

            WAIT_CNT: begin
                if (v_i) begin
                    cnt_d       = cnt_capped;
                    next_addr_d = last_addr_q + stride_sext;
                    if (cnt_capped == '0) begin
                        entry_v_d = 1'b0;
                        state_d   = TRAIN;
                    end else begin
                        state_d   = PREFETCH;
                    end
                end
            end

            PREFETCH: begin
                if (pf_ready_i) begin
                    next_addr_d = next_addr_q + stride_sext;
                    cnt_d       = cnt_q - cnt_width_lp'(1);
                    if (cnt_q == cnt_width_lp'(1)) begin
                        entry_v_d = 1'b0;
                        conf_d    = '0;
                        state_d   = TRAIN;
                    end
                end
            end

            default: state_d = TRAIN;
        endcase
    end

    // pf_v_o comes straight from the state register, so an asynchronous reset
    // drops it without waiting for a clock edge.
    always_comb begin
        yumi_o = 1'b0;
        pf_v_o = 1'b0;
        unique case (state_q)
            WAIT_CNT: yumi_o = v_i;
            PREFETCH: pf_v_o = 1'b1;
            default: ;
        endcase
    end

    assign start_discovery_o   = start_q;
    assign confirm_discovery_o = confirm_q;
    assign striding_pc_o       = pc_q;
    assign pf_addr_o           = next_addr_q;

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Directed bench for bp_be_stride_detector; prefetch addresses are checked
// against a scoreboard queue filled when the iteration estimate is presented.
module tb_bp_be_stride_detector;

    localparam int VA = 39;
    localparam int OR = 8;

    logic          clk;
    logic          reset_n_i;
    logic          ld_v_i;
    logic [VA-1:0] ld_pc_i;
    logic [VA-1:0] ld_eaddr_i;
    logic          start_discovery_o;
    logic          confirm_discovery_o;
    logic [VA-1:0] striding_pc_o;
    logic [OR-1:0] remaining_iterations_i;
    logic          v_i;
    logic          yumi_o;
    logic          pf_v_o;
    logic [VA-1:0] pf_addr_o;
    logic          pf_ready_i;

    int errors = 0;
    int checks = 0;
    logic [VA-1:0] sb[$];

    bp_be_stride_detector #(
        .vaddr_width_p   (VA),
        .output_range_p  (OR),
        .stride_width_p  (16),
        .conf_threshold_p(3),
        .max_prefetch_p  (16)
    ) dut (
        .clk_i                 (clk),
        .reset_n_i             (reset_n_i),
        .ld_v_i                (ld_v_i),
        .ld_pc_i               (ld_pc_i),
        .ld_eaddr_i            (ld_eaddr_i),
        .start_discovery_o     (start_discovery_o),
        .confirm_discovery_o   (confirm_discovery_o),
        .striding_pc_o         (striding_pc_o),
        .remaining_iterations_i(remaining_iterations_i),
        .v_i                   (v_i),
        .yumi_o                (yumi_o),
        .pf_v_o                (pf_v_o),
        .pf_addr_o             (pf_addr_o),
        .pf_ready_i            (pf_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
            $error("%s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One committed load, then the registered pulses it produces are checked.
    task automatic load(input logic [VA-1:0] pc, input logic [VA-1:0] addr,
                        input logic exp_start, input logic exp_confirm);
        ld_v_i     = 1'b1;
        ld_pc_i    = pc;
        ld_eaddr_i = addr;
        tick();
        ld_v_i     = 1'b0;
        check($sformatf("start@%0h", addr), start_discovery_o, exp_start);
        check($sformatf("confirm@%0h", addr), confirm_discovery_o, exp_confirm);
    endtask

    task automatic train5(input logic [VA-1:0] pc, input logic [VA-1:0] base, input logic [VA-1:0] stride);
        for (int i = 0; i < 5; i++)
            load(pc, base + stride * VA'(i), i == 2, i == 4);
    endtask

    // Present the estimate; the scoreboard receives the addresses the sink should see.
    task automatic begin_pf(input logic [7:0] rem, input logic [VA-1:0] last,
                            input logic [VA-1:0] stride, input int exp_n);
        v_i                    = 1'b1;
        remaining_iterations_i = rem;
        pf_ready_i             = 1'b1;
        #1;
        check("yumi_same_cycle", yumi_o, 1'b1);
        check("pf_v_before_yumi", pf_v_o, 1'b0);
        for (int k = 1; k <= exp_n; k++)
            sb.push_back(last + stride * VA'(k));
        tick();
        v_i = 1'b0;
    endtask

    task automatic drain(input int stall_at);
        int issued = 0;
        int stall  = 0;
        int cyc    = 0;
        while (sb.size() > 0) begin
            if (cyc >= 200) begin
                check("drain_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
                break;
            end
            pf_ready_i = !(issued == stall_at && stall < 4);
            #1;
            check($sformatf("pf_v[%0d]", issued), pf_v_o, 1'b1);
            check($sformatf("pf_addr[%0d]", issued), pf_addr_o, sb[0]);
            if (pf_ready_i) begin
                void'(sb.pop_front());
                issued++;
            end else begin
                stall++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        pf_ready_i = 1'b0;
        check("pf_v_after_drain", pf_v_o, 1'b0);
    endtask

    // v_i is only consumed in WAIT_CNT, so a silent yumi_o shows the FSM is elsewhere.
    task automatic check_not_waiting(input string tag);
        v_i                    = 1'b1;
        remaining_iterations_i = 8'd3;
        #1;
        check(tag, yumi_o, 1'b0);
        v_i = 1'b0;
    endtask

    initial begin
        reset_n_i              = 1'b0;
        ld_v_i                 = 1'b0;
        ld_pc_i                = '0;
        ld_eaddr_i             = '0;
        remaining_iterations_i = '0;
        v_i                    = 1'b0;
        pf_ready_i             = 1'b0;

        // Reset held before any clock edge.
        #2;
        check("rst_start", start_discovery_o, 1'b0);
        check("rst_confirm", confirm_discovery_o, 1'b0);
        check("rst_pc", striding_pc_o, '0);
        check("rst_yumi", yumi_o, 1'b0);
        check("rst_pf_v", pf_v_o, 1'b0);
        check("rst_pf_addr", pf_addr_o, '0);
        @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("idle_start", start_discovery_o, 1'b0);
            check("idle_confirm", confirm_discovery_o, 1'b0);
            tick();
        end

        // Train and confirm, then five prefetches at full throughput.
        load(39'h1000, 39'h8000, 1'b0, 1'b0);
        load(39'h1000, 39'h8008, 1'b0, 1'b0);
        load(39'h1000, 39'h8010, 1'b1, 1'b0);
        check("striding_pc", striding_pc_o, 39'h1000);
        load(39'h1000, 39'h8018, 1'b0, 1'b0);
        load(39'h1000, 39'h8020, 1'b0, 1'b1);
        begin_pf(8'd5, 39'h8020, 39'h8, 5);
        check("pc_stable_pf", striding_pc_o, 39'h1000);
        drain(-1);
        check_not_waiting("train_after_pf");

        // Cap at 16 with a 4-cycle stall after the third prefetch.
        train5(39'h2000, 39'hA000, 39'h10);
        begin_pf(8'd128, 39'hA040, 39'h10, 16);
        drain(3);
        check_not_waiting("train_after_cap");

        // Stride break during discovery, relearn, second start pulse.
        load(39'h3000, 39'hB000, 1'b0, 1'b0);
        load(39'h3000, 39'hB008, 1'b0, 1'b0);
        load(39'h3000, 39'hB010, 1'b1, 1'b0);
        load(39'h3000, 39'hB020, 1'b0, 1'b0);
        check_not_waiting("train_after_break");
        load(39'h3000, 39'hB030, 1'b1, 1'b0);
        load(39'h3000, 39'hB040, 1'b0, 1'b0);
        load(39'h3000, 39'hB050, 1'b0, 1'b1);
        begin_pf(8'd2, 39'hB050, 39'h10, 2);
        drain(-1);

        // Negative stride, zero iterations: consumed but nothing issued.
        train5(39'h4000, 39'h9000, -39'sd8);
        begin_pf(8'd0, 39'h8FE0, -39'sd8, 0);
        check("zero_cnt_no_pf", pf_v_o, 1'b0);
        check_not_waiting("train_after_zero");
        tick();
        check("zero_cnt_still_no_pf", pf_v_o, 1'b0);

        // Asynchronous reset while a prefetch is pending.
        train5(39'h5000, 39'hC000, 39'h4);
        begin_pf(8'd10, 39'hC010, 39'h4, 10);
        pf_ready_i = 1'b0;
        #1;
        check("pf_v_before_rst", pf_v_o, 1'b1);
        check("pf_addr_before_rst", pf_addr_o, 39'hC014);
        sb.delete();
        reset_n_i = 1'b0;
        #1;
        check("rst_mid_pf_v", pf_v_o, 1'b0);
        check("rst_mid_pf_addr", pf_addr_o, '0);
        check("rst_mid_pc", striding_pc_o, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
